// File: rtl/serial_operand_feeder_pkg.sv
// Shared types and defaults for the serial operand feeder and its neighbours.
package serial_operand_feeder_pkg;

    // Feeder sequencing: accept, serialise, wait for the adder, hold the result.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/serial_operand_feeder_if.sv
// Operand and result handshakes between the feeder and its environment.
// master is the environment (producer of operands, consumer of results);
// slave is the feeder itself.
interface serial_operand_feeder_if
    import serial_operand_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;

    modport master (
        output in_valid, op_x, op_y, res_ready,
        input  in_ready, res_valid, res_sum, res_cout
    );

    modport slave (
        input  in_valid, op_x, op_y, res_ready,
        output in_ready, res_valid, res_sum, res_cout
    );
endinterface

// File: rtl/serial_operand_feeder_piso_shiftreg.sv
// Parallel-in serial-out register: parallel load, shift right with zero fill,
// LSB is the serial output.
module piso_shiftreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);
    logic [WIDTH-1:0] data;

    // Load takes priority over shift; zero fill keeps drained bits clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= {1'b0, data[WIDTH-1:1]};
        end
    end

    assign sout = data[0];
endmodule

// File: rtl/serial_operand_feeder.sv
// Upstream controller for the bit-serial adder: accepts an operand pair,
// streams it LSB-first to the adder, captures the adder result and offers it
// downstream. A watchdog raises a sticky err if the adder never finishes.
module serial_operand_feeder
    import serial_operand_feeder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_operand_feeder_if.slave  bus,
    output logic                    bit_a,
    output logic                    bit_b,
    output logic                    start,
    input  logic                    adder_done,
    input  logic [WIDTH-1:0]        adder_sum,
    input  logic                    adder_cout,
    output logic                    err
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [WD_W-1:0]  wdog;
    logic             load;
    logic             shift;
    logic             capture;
    logic             timeout_hit;
    logic             x_bit;
    logic             y_bit;
    logic             in_ready;
    logic             res_valid;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             err_q;

    piso_shiftreg #(.WIDTH(WIDTH)) u_xsh (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (bus.op_x),
        .sout  (x_bit)
    );

    piso_shiftreg #(.WIDTH(WIDTH)) u_ysh (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (bus.op_y),
        .sout  (y_bit)
    );

    // Next state and all handshake/adder outputs decoded from the current state.
    always_comb begin
        state_next  = state;
        load        = 1'b0;
        shift       = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        start       = 1'b0;
        bit_a       = 1'b0;
        bit_b       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                start = 1'b1;
                bit_a = x_bit;
                bit_b = y_bit;
                shift = 1'b1;
                if (bit_cnt == CNT_W'(1)) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                start = 1'b1;
                if (adder_done) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit counter: loaded only on accept, so it can never wrap mid-operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= CNT_W'(WIDTH);
        end else if (shift) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
        end
    end

    // Watchdog counts cycles spent waiting for the adder, idle at zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog <= '0;
        end else if (state == WAIT_DONE) begin
            wdog <= wdog + WD_W'(1);
        end else begin
            wdog <= '0;
        end
    end

    // Result capture: the adder's value is taken verbatim and held through HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (capture) begin
            sum_q  <= adder_sum;
            cout_q <= adder_cout;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
    assign err           = err_q;
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Scoreboard bench for serial_operand_feeder with a behavioural serial adder.
module tb_serial_operand_feeder;
    import serial_operand_feeder_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int TO = DEFAULT_TIMEOUT;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } res_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         bit_a;
    logic         bit_b;
    logic         start;
    logic         adder_done;
    logic [W-1:0] adder_sum;
    logic         adder_cout;
    logic         err;

    serial_operand_feeder_if #(.WIDTH(W)) bus ();

    serial_operand_feeder #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .bit_a      (bit_a),
        .bit_b      (bit_b),
        .start      (start),
        .adder_done (adder_done),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .err        (err)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];
    res_t exp_item;
    int   start_cycles = 0;
    int   rv_cycles = 0;

    // Behavioural adder: collects W bits while start is high, then reports done.
    logic [W-1:0] acc_a;
    logic [W-1:0] acc_b;
    logic [W-1:0] cap_a;
    logic [W-1:0] cap_b;
    int           mcnt;
    logic         adder_stuck = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt = 0;
            acc_a = '0;
            acc_b = '0;
            adder_done <= 1'b0;
            adder_sum  <= '0;
            adder_cout <= 1'b0;
        end else if (!start) begin
            mcnt = 0;
            adder_done <= 1'b0;
        end else if (mcnt < W) begin
            acc_a[mcnt] = bit_a;
            acc_b[mcnt] = bit_b;
            mcnt++;
            if (mcnt == W) begin
                cap_a <= acc_a;
                cap_b <= acc_b;
                {adder_cout, adder_sum} <= {1'b0, acc_a} + {1'b0, acc_b};
                adder_done <= !adder_stuck;
            end
        end
    end

    // Counts cycles with start high, sampled mid-cycle.
    always @(negedge clk) begin
        if (start) start_cycles++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted result is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.res_valid) rv_cycles++;
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_result: got sum 0x%0h, expected no result",
                             bus.res_sum);
                end else begin
                    exp_item = exp_q.pop_front();
                    checkOutput("res_sum", 32'(bus.res_sum), 32'(exp_item.sum));
                    checkOutput("res_cout", 32'(bus.res_cout), 32'(exp_item.cout));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] esum, input logic ecout,
                                 input bit push);
        bit   ok;
        res_t r;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.op_x = x;
        bus.op_y = y;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1");
        end else if (push) begin
            r.sum = esum;
            r.cout = ecout;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int s0;
        int r0;
        int bad;
        bit ok;
        bus.in_valid = 1'b0;
        bus.op_x = '0;
        bus.op_y = '0;
        bus.res_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_res_sum", 32'(bus.res_sum), 32'd0);
        checkOutput("rst_res_cout", 32'(bus.res_cout), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_bit_a", 32'(bit_a), 32'd0);
        checkOutput("rst_bit_b", 32'(bit_b), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 0x66 + 0x72 = 0xD8
        applyStimulus(8'h66, 8'h72, 8'hD8, 1'b0, 1'b1);
        waitDrain();
        checkOutput("op1_bits_a", 32'(cap_a), 32'h66);
        checkOutput("op1_bits_b", 32'(cap_b), 32'h72);

        // 0xFF + 0x01 = 0x100; start high for W shift cycles plus one wait cycle
        s0 = start_cycles;
        applyStimulus(8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        waitDrain();
        checkOutput("op2_start_cycles", 32'(start_cycles - s0), 32'(W + 1));

        // Backpressure: 0x12 + 0x34 = 0x46 held for 10 cycles
        bus.res_ready = 1'b0;
        applyStimulus(8'h12, 8'h34, 8'h46, 1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("bp_res_valid_seen", 32'(ok), 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(bus.res_valid && bus.res_sum == 8'h46 && !bus.in_ready)) bad++;
        end
        checkOutput("bp_hold_stable", 32'(bad), 32'd0);
        checkOutput("bp_hold_sum", 32'(bus.res_sum), 32'h46);
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("bp_idle_res_valid", 32'(bus.res_valid), 32'd0);

        // in_valid pulse during SHIFT must be ignored
        applyStimulus(8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.op_x = 8'h80;
        bus.op_y = 8'h80;
        checkOutput("busy_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waitDrain();
        checkOutput("busy_bits_a", 32'(cap_a), 32'h0F);
        checkOutput("busy_bits_b", 32'(cap_b), 32'hF0);
        applyStimulus(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        waitDrain();

        // Reset in the 4th SHIFT cycle
        applyStimulus(8'h3C, 8'h5A, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_start", 32'(start), 32'd0);
        checkOutput("midrst_bit_a", 32'(bit_a), 32'd0);
        checkOutput("midrst_bit_b", 32'(bit_b), 32'd0);
        checkOutput("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(8'h81, 8'h01, 8'h82, 1'b0, 1'b1);
        waitDrain();
        checkOutput("postrst_bits_a", 32'(cap_a), 32'h81);

        // Watchdog: adder never finishes
        adder_stuck = 1'b1;
        s0 = start_cycles;
        r0 = rv_cycles;
        applyStimulus(8'h11, 8'h22, 8'h00, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (err) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("to_err", 32'(ok), 32'd1);
        checkOutput("to_start_cycles", 32'(start_cycles - s0), 32'(W + TO));
        checkOutput("to_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("to_no_result", 32'(rv_cycles - r0), 32'd0);
        adder_stuck = 1'b0;
        applyStimulus(8'h01, 8'h01, 8'h02, 1'b0, 1'b1);
        waitDrain();
        checkOutput("to_err_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("to_err_cleared", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL leftover_results: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream controller for the 8-bit bit-serial adder.
- Accepts two parallel operands through a valid/ready handshake and serialises them LSB-first onto the adder's bit inputs, one bit per clock, while holding the adder's start high.
- Waits for the adder's done, captures its parallel sum and carry-out, and presents them downstream through a second valid/ready handshake.
- A watchdog flags an adder that never asserts done.

Parameters:
- WIDTH, 8, operand and sum width in bits; matches the adder's shift registers.
- TIMEOUT, 32, maximum cycles in WAIT_DONE before err asserts; must be ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  feeder can accept an operand pair.
- op_x  in  WIDTH  first operand.
- op_y  in  WIDTH  second operand.
- bit_a  out  1  serial bit of op_x to the adder.
- bit_b  out  1  serial bit of op_y to the adder.
- start  out  1  adder enable; high in SHIFT and WAIT_DONE.
- adder_done  in  1  adder has finished.
- adder_sum  in  WIDTH  adder parallel sum.
- adder_cout  in  1  adder carry-out.
- res_valid  out  1  result held for the consumer.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  WIDTH  captured sum.
- res_cout  out  1  captured carry-out.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, any state, including mid-shift):
  - state=IDLE; shift registers, counter and watchdog cleared.
  - in_ready=1, res_valid=0, res_sum=0, res_cout=0, err=0.
  - start=0, bit_a=0, bit_b=0.
- FSM states: IDLE, SHIFT, WAIT_DONE, HOLD.
- IDLE:
  - in_ready=1, start=0.
  - On in_valid&in_ready: latch op_x and op_y into xsh and ysh, load bit counter=WIDTH, move to SHIFT at the next edge.
- SHIFT:
  - in_ready=0, start=1, bit_a=xsh[0], bit_b=ysh[0]. Outputs are combinational from the registers, so a bit is stable for the whole cycle before the adder samples it.
  - Each edge: shift xsh and ysh right by one (zero fill) and decrement the counter.
  - When the counter is 1 at the edge, move to WAIT_DONE. Exactly WIDTH cycles are spent in SHIFT; bit i is presented in cycle i (i=0 is the LSB).
- WAIT_DONE:
  - start=1, bit_a=0, bit_b=0, watchdog increments each cycle.
  - On adder_done=1 at an edge: capture res_sum<=adder_sum, res_cout<=adder_cout, set res_valid=1, move to HOLD.
  - On watchdog==TIMEOUT-1 with no done: set err=1, capture nothing, return to IDLE.
  - If done and the timeout coincide, done wins.
- HOLD:
  - start=0, in_ready=0, res_valid=1; res_sum and res_cout stay stable until the transfer.
  - On res_valid&res_ready: clear res_valid, move to IDLE. Transfer-then-accept takes at least one cycle; there is no same-cycle re-accept.
- Boundary conditions:
  - in_valid while busy is ignored (in_ready=0); the upstream must hold the pair.
  - adder_done in IDLE, SHIFT or HOLD is ignored.
  - err clears only on reset.
  - The counter never wraps: it is loaded only in IDLE.
- Width rules:
  - Counter and watchdog widths are clog2(WIDTH+1) and clog2(TIMEOUT+1).
  - The sum is not recomputed locally; the adder's value is captured verbatim.
- Throughput: 1 accept cycle + WIDTH shift cycles + adder latency + ≥1 hold cycle per operation.

Decomposition:
- Shared package: state enum (IDLE, SHIFT, WAIT_DONE, HOLD) and a localparam for the default WIDTH=8, reused by the adder wrapper and the bench.
- One natural sub-module, piso_shiftreg: parallel load plus shift-right with zero fill; LSB is the serial output. Instantiate it twice, for X and Y.
- The FSM, counter and watchdog stay in the top module.

Test Plan:
- Reset, then op_x=0x66, op_y=0x72 with a behavioural adder model -> bit_a sequence 0,1,1,0,0,1,1,0 and bit_b sequence 0,1,0,0,1,1,1,0 over 8 SHIFT cycles; then res_sum=0xD8, res_cout=0, res_valid=1.
- op_x=0xFF, op_y=0x01 -> res_sum=0x00, res_cout=1; start high for exactly 8 cycles plus the WAIT_DONE cycles.
- Backpressure: hold res_ready=0 for 10 cycles after done -> res_valid and res_sum stable, in_ready=0 throughout; res_ready=1 -> IDLE next cycle with in_ready=1.
- New in_valid pulse during SHIFT -> ignored; shifted bits unchanged; second pair accepted only after the HOLD transfer.
- Assert reset at the 4th SHIFT cycle -> start=0, bit_a=0, res_valid=0 immediately (asynchronous), state IDLE; the next pair serialises from its bit 0.
- adder_done tied 0, TIMEOUT=32 -> err=1 after 32 WAIT_DONE cycles, return to IDLE with in_ready=1, res_valid never asserted; err stays set until reset.
